count_sampler: RTL and testbench



---
 rtl/count_sampler.sv | 126 ++++++++++++
 tb/tb_count_sampler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/count_sampler.sv
// ============================================================================
// Module   : count_sampler
// Purpose  : Samples an upstream free-running counter on request, tags each
//            sample with a "counter wrapped since last accepted sample" bit,
//            buffers the tagged samples in a small FIFO and presents them on a
//            valid/ready interface. A sticky flag records dropped samples.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_sampler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           count_in,
  input  logic                       sample_en,
  input  logic                       out_ready,
  input  logic                       clear_ovf,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_wrap,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] C_FULL_LEVEL = LW'(DEPTH);

  // Each entry is {wrap tag, sample value}
  logic [WIDTH:0]     mem_q [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [WIDTH-1:0]   prev_q;
  logic               wrap_pending_q, wrap_pending_d;
  logic               overflow_q, overflow_d;

  logic               fifo_full;
  logic               do_pop;
  logic               do_push;
  logic               do_drop;
  logic               wrap_evt;
  logic [WIDTH:0]     wr_entry;

  // Handshake decode, wrap detection and next-state for pointers and flags
  always_comb begin
    fifo_full      = (level_q == C_FULL_LEVEL);
    do_pop         = (level_q != '0) && out_ready;
    // A full FIFO that is popping this cycle frees a slot for the push
    do_push        = sample_en && (!fifo_full || do_pop);
    do_drop        = sample_en && fifo_full && !do_pop;
    wrap_evt       = (count_in < prev_q);
    wr_entry       = {wrap_pending_q | wrap_evt, count_in};

    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    level_d        = level_q;
    wrap_pending_d = wrap_pending_q | wrap_evt;
    overflow_d     = overflow_q;

    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push) begin
      wr_ptr_d       = wr_ptr_q + PW'(1);
      // The pending wrap has been delivered with this sample
      wrap_pending_d = 1'b0;
    end

    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear request keeps the flag set
    if (do_drop) begin
      overflow_d = 1'b1;
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Control state: pointers, occupancy, wrap tracking and overflow flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      level_q        <= '0;
      prev_q         <= '0;
      wrap_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      level_q        <= level_d;
      prev_q         <= count_in;
      wrap_pending_q <= wrap_pending_d;
      overflow_q     <= overflow_d;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero when empty
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Outputs are driven purely from registered state
  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q][WIDTH-1:0];
  assign out_wrap  = mem_q[rd_ptr_q][WIDTH];
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_count_sampler.sv
// ============================================================================
// Module   : tb_count_sampler
// Purpose  : Self-checking bench for count_sampler using a scoreboard queue of
//            expected {wrap, data} entries filled as samples are requested.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_sampler;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] count_in;
  logic             sample_en;
  logic             out_ready;
  logic             clear_ovf;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_wrap;
  logic [LW-1:0]    level;
  logic             overflow;

  count_sampler #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .count_in  (count_in),
    .sample_en (sample_en),
    .out_ready (out_ready),
    .clear_ovf (clear_ovf),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_wrap  (out_wrap),
    .level     (level),
    .overflow  (overflow)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [WIDTH:0]   sb_q[$];
  int               m_level;
  logic             m_ovf;
  logic             m_pend;
  logic [WIDTH-1:0] m_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_level = 0;
    m_ovf   = 1'b0;
    m_pend  = 1'b0;
    m_prev  = '0;
  endtask

  // One clock cycle: entered and left at posedge+1
  task automatic cycle(input logic se, input logic [WIDTH-1:0] cnt,
                       input logic rdy, input logic clr);
    logic           pop, push, drop, wev, full;
    logic [WIDTH:0] exp;
    sample_en = se;
    count_in  = cnt;
    out_ready = rdy;
    clear_ovf = clr;
    #1;
    pop  = (m_level != 0) && rdy;
    full = (m_level == DEPTH);
    push = se && (!full || pop);
    drop = se && full && !pop;
    wev  = (cnt < m_prev);
    if (pop) begin
      exp = sb_q.pop_front();
      check("pop_data", 32'(out_data), 32'(exp[WIDTH-1:0]));
      check("pop_wrap", 32'(out_wrap), 32'(exp[WIDTH]));
    end
    if (push) sb_q.push_back({m_pend | wev, cnt});
    m_pend  = push ? 1'b0 : (m_pend | wev);
    m_ovf   = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_level = m_level + (push ? 1 : 0) - (pop ? 1 : 0);
    m_prev  = cnt;
    @(posedge clock);
    #1;
    check("level", 32'(level), 32'(m_level));
    check("valid", 32'(out_valid), 32'(m_level != 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (m_level != 0) begin
      check("head_data", 32'(out_data), 32'(sb_q[0][WIDTH-1:0]));
      check("head_wrap", 32'(out_wrap), 32'(sb_q[0][WIDTH]));
    end
  endtask

  logic [WIDTH-1:0] rcnt;

  initial begin
    reset     = 1'b1;
    count_in  = '0;
    sample_en = 1'b0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    model_reset();
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_data",  32'(out_data), 32'd0);
    check("rst_wrap",  32'(out_wrap), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Single sample, one-cycle latency, then consumed
    cycle(1'b1, 8'd5, 1'b1, 1'b0);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data",  32'(out_data), 32'd5);
    check("t1_wrap",  32'(out_wrap), 32'd0);
    check("t1_level", 32'(level), 32'd1);
    cycle(1'b0, 8'd5, 1'b1, 1'b0);
    check("t1_empty", 32'(out_valid), 32'd0);

    // Wrap tagging across unsampled cycles
    cycle(1'b0, 8'd250, 1'b0, 1'b0);
    cycle(1'b0, 8'd252, 1'b0, 1'b0);
    cycle(1'b0, 8'd254, 1'b0, 1'b0);
    cycle(1'b0, 8'd1,   1'b0, 1'b0);
    cycle(1'b0, 8'd3,   1'b0, 1'b0);
    cycle(1'b1, 8'd4,   1'b0, 1'b0);
    check("t2_wrap1", 32'(out_wrap), 32'd1);
    check("t2_data1", 32'(out_data), 32'd4);
    cycle(1'b1, 8'd6,   1'b1, 1'b0);
    check("t2_wrap0", 32'(out_wrap), 32'd0);
    check("t2_data0", 32'(out_data), 32'd6);
    cycle(1'b0, 8'd6,   1'b1, 1'b0);

    // Fill, drop, drain
    for (int i = 10; i <= 13; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    check("t3_full", 32'(level), 32'd4);
    cycle(1'b1, 8'd14, 1'b0, 1'b0);
    check("t3_ovf",   32'(overflow), 32'd1);
    check("t3_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'd14, 1'b1, 1'b0);
    check("t3_drained", 32'(out_valid), 32'd0);
    cycle(1'b0, 8'd14, 1'b0, 1'b1);
    check("t3_ovf_clr", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 10; i <= 13; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'd20, 1'b1, 1'b0);
    check("t4_level", 32'(level), 32'd4);
    check("t4_head",  32'(out_data), 32'd11);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'd20, 1'b1, 1'b0);
    check("t4_ovf", 32'(overflow), 32'd0);

    // Drop and clear in the same cycle: set wins
    for (int i = 21; i <= 24; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'd25, 1'b0, 1'b1);
    check("t5_race", 32'(overflow), 32'd1);
    cycle(1'b0, 8'd25, 1'b0, 1'b1);
    check("t5_clear", 32'(overflow), 32'd0);

    // Async reset with 3 entries, wrap pending and overflow set
    cycle(1'b1, 8'd26, 1'b0, 1'b0);
    cycle(1'b0, 8'd26, 1'b1, 1'b0);
    cycle(1'b0, 8'd2,  1'b0, 1'b0);
    check("t6_pre_level", 32'(level), 32'd3);
    check("t6_pre_ovf",   32'(overflow), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_ovf",   32'(overflow), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    cycle(1'b1, 8'd3, 1'b0, 1'b0);
    check("t6_wrap", 32'(out_wrap), 32'd0);
    check("t6_data", 32'(out_data), 32'd3);
    cycle(1'b0, 8'd3, 1'b1, 1'b0);

    // Sustained one-per-cycle throughput
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(40 + i), 1'b1, 1'b0);
    check("t7_level", 32'(level), 32'd1);

    // Random traffic with frequent counter wraps
    rcnt = 8'd200;
    for (int i = 0; i < 60; i++) begin
      rcnt = rcnt + 8'($urandom_range(0, 90));
      cycle(1'($urandom_range(0, 1)), rcnt, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, rcnt, 1'b1, 1'b0);
    check("final_empty", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
